cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports i_read  input  1  I-cache line-fill request; i_address  input  16  (lc3b_word) line address.
REQ-004 SHALL have ports i_rdata  output  128  (lc3b_line) fill data; i_resp  output  1  I-side completion pulse.
REQ-005 SHALL have ports d_read, d_write  input  1 each; d_address  input  16; d_wdata  input  128  writeback line.
REQ-006 SHALL have ports d_rdata  output  128; d_resp  output  1  D-side completion pulse.
REQ-007 SHALL have ports pmem_read, pmem_write  output  1 each; pmem_address  output  16; pmem_wdata  output  128.
REQ-008 SHALL have ports pmem_rdata  input  128; pmem_resp  input  1  physical-memory completion.
REQ-009 SHALL have ports i_grants, d_grants  output  16 each  grant counters, wrap modulo 2^16.

Function
REQ-010 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; IDLE on reset.
REQ-011 IDLE: only I requesting -> SERVE_I; only D (d_read|d_write) -> SERVE_D; none -> stay IDLE.
REQ-012 Both requesting in IDLE: grant side not granted last (last_grant register, resets to I, so first conflict grants D).
REQ-013 Transition out of IDLE SHALL increment the granted side's counter that same edge; 0xFFFF wraps to 0x0000.
REQ-014 In IDLE, pmem_read, pmem_write, i_resp, d_resp SHALL be 0; pmem_address/pmem_wdata don't-care.
REQ-015 SERVE_I: pmem_read=1, pmem_write=0, pmem_address=i_address.
REQ-016 SERVE_D: pmem_read=d_read & ~d_write, pmem_write=d_write, pmem_address=d_address, pmem_wdata=d_wdata.
REQ-017 d_read and d_write both high SHALL be treated as write.
REQ-018 pmem_resp in SERVE_x SHALL combinationally assert x_resp same cycle; x_rdata=pmem_rdata; FSM -> IDLE next edge.
REQ-019 i_rdata and d_rdata SHALL always equal pmem_rdata; only resp qualifies them.
REQ-020 Non-served side's resp SHALL be 0 in every cycle.
REQ-021 Requester dropping its request mid-service SHALL NOT abort; FSM holds state until pmem_resp.
REQ-022 pmem_resp while IDLE SHALL be ignored (no resp, no state change).
REQ-023 Minimum transaction latency: request cycle (IDLE) + one SERVE cycle; back-to-back grants separated by one IDLE cycle.
REQ-024 Requesters SHALL hold request and address stable until their resp; arbiter need not latch them.

Reset
REQ-025 rst high at an edge SHALL force IDLE, last_grant=I, i_grants=d_grants=0, overriding all other inputs.
REQ-026 Reset mid-transaction SHALL abandon it; no resp issued for it after reset.
REQ-027 Outputs during and after reset SHALL be pmem_read=pmem_write=i_resp=d_resp=0 until a new grant.

Structure
REQ-028 lc3b_word and lc3b_line (128-bit) SHALL come from package lc3b_types; arbiter state enum lc3b_arb_state SHALL be added there.
REQ-029 No sub-module required; datapath steering inline; counters and last_grant inside cache_arbiter.
REQ-030 Block SHALL sit between cache pair and physical memory, leaving both caches' interfaces unchanged.

Verification
REQ-031 i_read=1, i_address=0x1230, pmem_resp after 3 SERVE cycles, pmem_rdata=pattern A -> pmem_read=1, i_resp 1 cycle, i_rdata=A, i_grants=1.
REQ-032 d_write=1, d_address=0x4000, d_wdata=B -> pmem_write=1, pmem_read=0, pmem_wdata=B, d_resp on pmem_resp, d_grants=1.
REQ-033 i_read and d_read held continuously from reset, 4 transactions -> grant order D,I,D,I; counters 2/2.
REQ-034 rst asserted during SERVE_D before pmem_resp -> next cycle IDLE, no d_resp, counters 0, pmem strobes 0.
REQ-035 pmem_resp pulsed in IDLE with no requests -> no resp, state IDLE; d_read=d_write=1 -> pmem_write=1 only.
REQ-036 Preload i_grants to 0xFFFF via 65535 I transactions, one more -> i_grants=0x0000.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: word/line widths and the arbiter
// state encoding used by cache_arbiter.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  // Arbiter state: idle, or owning physical memory on behalf of one cache.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } lc3b_arb_state;

  // Which cache was granted most recently; used to alternate on conflicts.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } lc3b_arb_side;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates the I-cache and D-cache line interfaces onto a single
// physical-memory port. The caches keep their own interfaces unchanged;
// request/address/data are steered combinationally, never latched.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ARB_IDLE    | no owner; choose a requester, bump its grant counter
// ARB_SERVE_I | memory driven from I side, wait for pmem_resp
// ARB_SERVE_D | memory driven from D side (write wins), wait for pmem_resp
module cache_arbiter
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst,

  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,

  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,

  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,

  output logic [15:0]  i_grants,
  output logic [15:0]  d_grants
);

  lc3b_arb_state state;
  lc3b_arb_state state_next;
  lc3b_arb_side  last_grant;
  logic          d_req;
  logic          grant_i;
  logic          grant_d;

  // A read+write combination still counts as a single D request.
  assign d_req = d_read | d_write;

  // Next-state and grant selection; conflicts go to the side not granted last.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (i_read && d_req) begin
          if (last_grant == GRANT_I) grant_d = 1'b1;
          else                       grant_i = 1'b1;
        end else if (i_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_next = ARB_SERVE_I;
        if (grant_d) state_next = ARB_SERVE_D;
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (pmem_resp) state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // State, fairness bit and grant counters; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_I;
      i_grants   <= 16'h0000;
      d_grants   <= 16'h0000;
    end else begin
      state <= state_next;
      if (grant_i) begin
        last_grant <= GRANT_I;
        i_grants   <= i_grants + 16'd1;
      end
      if (grant_d) begin
        last_grant <= GRANT_D;
        d_grants   <= d_grants + 16'd1;
      end
    end
  end

  // Read data is broadcast to both caches; only the resp pulse qualifies it.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // Memory-side steering and completion pulses for the current owner.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = i_address;
    pmem_wdata   = d_wdata;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    case (state)
      ARB_SERVE_I: begin
        pmem_read    = 1'b1;
        pmem_address = i_address;
        i_resp       = pmem_resp;
      end
      ARB_SERVE_D: begin
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_address = d_address;
        d_resp       = pmem_resp;
      end
      default: begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios with literal expectations,
// a long grant-counter wrap run, then randomized traffic; a reference
// model of ownership/grants is compared every cycle.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  i_grants;
  logic [15:0]  d_grants;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .i_grants     (i_grants),
    .d_grants     (d_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns memory (0 none, 1 I, 2 D), who won last,
  // and how many grants each side has had (mod 65536).
  int m_owner  = 0;
  bit m_last_d = 1'b0;
  int m_ig     = 0;
  int m_dg     = 0;
  bit m_valid  = 1'b0;
  bit m_dreq;
  bit m_pick_i;

  assign m_dreq   = d_read | d_write;
  assign m_pick_i = i_read && (!m_dreq || m_last_d);

  always @(posedge clk) begin
    if (rst) begin
      m_owner  <= 0;
      m_last_d <= 1'b0;
      m_ig     <= 0;
      m_dg     <= 0;
      m_valid  <= 1'b1;
    end else if (m_valid) begin
      if (m_owner == 0) begin
        if (m_pick_i) begin
          m_owner  <= 1;
          m_last_d <= 1'b0;
          m_ig     <= (m_ig + 1) % 65536;
        end else if (m_dreq) begin
          m_owner  <= 2;
          m_last_d <= 1'b1;
          m_dg     <= (m_dg + 1) % 65536;
        end
      end else if (pmem_resp) begin
        m_owner <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, well away from the clock edge.
  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      logic e_rd, e_wr, e_ir, e_dr;
      e_rd = (m_owner == 1) || (m_owner == 2 && d_read && !d_write);
      e_wr = (m_owner == 2) && d_write;
      e_ir = (m_owner == 1) && pmem_resp;
      e_dr = (m_owner == 2) && pmem_resp;
      chk("m_pmem_read",  128'(pmem_read),  128'(e_rd));
      chk("m_pmem_write", 128'(pmem_write), 128'(e_wr));
      chk("m_i_resp",     128'(i_resp),     128'(e_ir));
      chk("m_d_resp",     128'(d_resp),     128'(e_dr));
      chk("m_i_rdata",    i_rdata,          pmem_rdata);
      chk("m_d_rdata",    d_rdata,          pmem_rdata);
      chk("m_i_grants",   128'(i_grants),   128'(m_ig));
      chk("m_d_grants",   128'(d_grants),   128'(m_dg));
      if (m_owner == 1) chk("m_addr_i", 128'(pmem_address), 128'(i_address));
      if (m_owner == 2) begin
        chk("m_addr_d",  128'(pmem_address), 128'(d_address));
        chk("m_wdata_d", pmem_wdata,         d_wdata);
      end
    end
  end

  localparam logic [127:0] PAT_A = 128'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98_5A5A;
  localparam logic [127:0] PAT_B = 128'h0F0F_1111_2222_3333_4444_5555_6666_F0F0;

  int ord [4];
  int got;
  logic [15:0] cap_ig, cap_dg;

  initial begin
    rst = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    cap_ig = '0; cap_dg = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_i_grants",   128'(i_grants),   128'(16'h0000));
    chk("rst_d_grants",   128'(d_grants),   128'(16'h0000));
    chk("rst_pmem_read",  128'(pmem_read),  128'(1'b0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(1'b0));

    // I-side line fill, memory answers on the fourth SERVE cycle
    @(negedge clk);
    rst = 1'b0; i_read = 1'b1; i_address = 16'h1230;
    @(negedge clk); #3;
    chk("t1_pmem_read", 128'(pmem_read),    128'(1'b1));
    chk("t1_addr",      128'(pmem_address), 128'(16'h1230));
    chk("t1_i_grants",  128'(i_grants),     128'(16'h0001));
    chk("t1_no_resp",   128'(i_resp),       128'(1'b0));
    repeat (2) @(negedge clk);
    @(negedge clk);
    pmem_rdata = PAT_A; pmem_resp = 1'b1;
    #3;
    chk("t1_i_resp",  128'(i_resp), 128'(1'b1));
    chk("t1_i_rdata", i_rdata,      PAT_A);
    chk("t1_d_resp",  128'(d_resp), 128'(1'b0));
    @(negedge clk);
    pmem_resp = 1'b0; i_read = 1'b0;
    #3;
    chk("t1_idle_resp", 128'(i_resp),    128'(1'b0));
    chk("t1_idle_read", 128'(pmem_read), 128'(1'b0));

    // D-side writeback answered in its first SERVE cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_write = 1'b1; d_address = 16'h4000; d_wdata = PAT_B;
    @(negedge clk);
    pmem_resp = 1'b1;
    #3;
    chk("t2_pmem_write", 128'(pmem_write),   128'(1'b1));
    chk("t2_pmem_read",  128'(pmem_read),    128'(1'b0));
    chk("t2_wdata",      pmem_wdata,         PAT_B);
    chk("t2_addr",       128'(pmem_address), 128'(16'h4000));
    chk("t2_d_resp",     128'(d_resp),       128'(1'b1));
    chk("t2_i_resp",     128'(i_resp),       128'(1'b0));
    chk("t2_d_grants",   128'(d_grants),     128'(16'h0001));
    @(negedge clk);
    pmem_resp = 1'b0; d_write = 1'b0;

    // Both sides requesting continuously from reset: D,I,D,I
    rst = 1'b1; i_read = 1'b1; d_read = 1'b1; pmem_resp = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk); #3;
      if (d_resp && got < 4) begin ord[got] = 2; got++; end
      if (i_resp && got < 4) begin ord[got] = 1; got++; end
      if (got == 4) begin cap_ig = i_grants; cap_dg = d_grants; end
    end
    chk("t3_resp_count", 128'(got), 128'(4));
    chk("t3_order0", 128'(ord[0]), 128'(2));
    chk("t3_order1", 128'(ord[1]), 128'(1));
    chk("t3_order2", 128'(ord[2]), 128'(2));
    chk("t3_order3", 128'(ord[3]), 128'(1));
    chk("t3_i_grants", 128'(cap_ig), 128'(16'h0002));
    chk("t3_d_grants", 128'(cap_dg), 128'(16'h0002));
    @(negedge clk);
    i_read = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;

    // Reset during SERVE_D abandons the transaction
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d_read = 1'b1;
    @(negedge clk); #3;
    chk("t4_serving",  128'(pmem_read), 128'(1'b1));
    chk("t4_d_grants", 128'(d_grants),  128'(16'h0001));
    rst = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b1;
    #3;
    chk("t4_no_d_resp", 128'(d_resp),     128'(1'b0));
    chk("t4_read0",     128'(pmem_read),  128'(1'b0));
    chk("t4_write0",    128'(pmem_write), 128'(1'b0));
    chk("t4_d_cnt0",    128'(d_grants),   128'(16'h0000));
    chk("t4_i_cnt0",    128'(i_grants),   128'(16'h0000));
    @(negedge clk);
    rst = 1'b0; d_read = 1'b0; pmem_resp = 1'b0;

    // Stray pmem_resp while idle, then read+write treated as write
    @(negedge clk);
    pmem_resp = 1'b1;
    #3;
    chk("t5_i_resp", 128'(i_resp),    128'(1'b0));
    chk("t5_d_resp", 128'(d_resp),    128'(1'b0));
    chk("t5_read",   128'(pmem_read), 128'(1'b0));
    @(negedge clk); #3;
    chk("t5_still_idle", 128'(pmem_read | pmem_write | i_resp | d_resp), 128'(1'b0));
    pmem_resp = 1'b0; d_read = 1'b1; d_write = 1'b1;
    @(negedge clk); #3;
    chk("t5_rw_write", 128'(pmem_write), 128'(1'b1));
    chk("t5_rw_read",  128'(pmem_read),  128'(1'b0));
    chk("t5_d_grants", 128'(d_grants),   128'(16'h0001));
    pmem_resp = 1'b1;
    @(negedge clk);
    d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;

    // 65535 back-to-back I transactions, then one more wraps the counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_read = 1'b1; pmem_resp = 1'b1;
    repeat (2 * 65535) @(negedge clk);
    #3;
    chk("t6_i_grants_max", 128'(i_grants),  128'(16'hFFFF));
    chk("t6_idle",         128'(pmem_read), 128'(1'b0));
    @(negedge clk); #3;
    chk("t6_i_grants_wrap", 128'(i_grants),  128'(16'h0000));
    chk("t6_serving",       128'(pmem_read), 128'(1'b1));
    @(negedge clk);
    i_read = 1'b0; pmem_resp = 1'b0; rst = 1'b1;

    // Randomized traffic, including occasional reset and dropped requests
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) < 2);
      i_read     = ($urandom_range(0, 2) != 0);
      d_read     = $urandom_range(0, 1) == 1;
      d_write    = ($urandom_range(0, 3) == 0);
      i_address  = 16'($urandom);
      d_address  = 16'($urandom);
      d_wdata    = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp  = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
